counter_sched: RTL
==================

# counter_sched

Round-robin scheduler that shares one up-counter timing resource among `NUM_REQ` requesters. A requester asks for an interval of `duration` clock cycles. The block grants the counter to one requester at a time, counts the interval, and pulses `done` to the owner. It sits between client blocks needing cycle-accurate delays and the free-running counter datapath, so the design instantiates one counter instead of one per client.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `COUNT_WIDTH`, default 32: counter and duration width.

Ports:
- `clk`, in, 1: single clock; all state changes on posedge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_req`, in, `NUM_REQ`: level request, one bit per requester.
- `i_duration`, in, `NUM_REQ*COUNT_WIDTH`: packed durations; requester k uses bits `[k*COUNT_WIDTH +: COUNT_WIDTH]`.
- `o_grant`, out, `NUM_REQ`: one-hot owner of the counter; all zero when idle.
- `o_done`, out, `NUM_REQ`: one-cycle completion pulse to the owner.
- `o_busy`, out, 1: high in RUN and DONE.
- `o_count`, out, `COUNT_WIDTH`: current interval count.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - If `i_req` is nonzero, pick the winner by round robin, starting from (`last_grant`+1) mod `NUM_REQ`.
  - Latch the winner's `i_duration` into `dur_q`. Set `o_grant` to the winner, set count to 0, update `last_grant`, go to RUN.
  - If `i_req` is zero, stay in IDLE.
- RUN:
  - If count == `dur_q`, go to DONE and hold the count.
  - Otherwise count increments by 1.
  - Count never wraps: the maximum `dur_q` of 2^`COUNT_WIDTH`-1 is reached without overflow.
- DONE:
  - `o_done` equals `o_grant` for exactly this cycle.
  - Next state is always IDLE, with `o_grant` cleared and count cleared to 0.
- `i_duration` is sampled only at grant. Changes during RUN are ignored.
- Requests are levels. A requester whose `i_req` is still high after DONE re-competes normally. The round-robin pointer gives every other pending requester precedence first.
- Reset values: `o_grant`=0, `o_done`=0, `o_busy`=0, `o_count`=0, `dur_q`=0, state IDLE, `last_grant`=`NUM_REQ`-1, so requester 0 has top priority after reset.
- Reset mid-operation: the interval is abandoned immediately, no `o_done` pulse is issued, and all outputs take their reset values on the next edge.
- Duration 0: RUN lasts 1 cycle, then DONE.

## Timing
- All outputs are registered.
- Request first sampled high at edge E:
  - `o_grant` and `o_busy` go high after E.
  - `o_count` reads 0..`dur_q` across the following `dur_q`+1 RUN cycles.
  - `o_done` is high in cycle E+`dur_q`+2, counting cycles after E.
- Grant duration: `o_grant` is high for `dur_q`+2 cycles (RUN plus DONE).
- Back-to-back intervals always have 1 IDLE cycle between DONE and the next grant.
- Request-to-done latency is `dur_q`+2 cycles when the block is idle. Worst-case wait before a grant is (`NUM_REQ`-1) full intervals plus 1 cycle for each of them.

## Configuration
- `COUNTER_SCHED_CANCEL_EN` defined:
  - If the owner's `i_req` is low during any RUN cycle, the next state is IDLE, `o_grant` clears and count clears to 0.
  - No `o_done` pulse is issued.
  - `last_grant` still advances.
- Not defined: `i_req` is ignored once granted. The interval always runs to completion and pulses `o_done`.

## Test plan
- Single request:
  - Stimulus: reset, then `i_req`=4'b0001 with duration 5.
  - Required: `o_grant`=0001 for 7 cycles; `o_count` steps 0,1,2,3,4,5; `o_done`=0001 in the 7th grant cycle; `o_busy` drops the cycle after.
- Round robin:
  - Stimulus: `i_req`=1111 held, all durations 2.
  - Required: grant order is 0,1,2,3,0 with exactly 1 idle cycle between grants.
- Boundary durations:
  - Stimulus: duration 0, then duration 2^`COUNT_WIDTH`-1 with `COUNT_WIDTH`=8.
  - Required: DONE follows 1 RUN cycle for duration 0. For 255, the count reaches 255 with no wrap and `o_done` arrives 257 cycles after grant.
- Reset mid-run:
  - Stimulus: assert `i_reset` at count 3 of a duration-10 interval.
  - Required: next cycle all outputs are 0 with no `o_done`. After reset, requester 0 wins against `i_req`=1001.
- Duration sampling:
  - Stimulus: change `i_duration` during RUN.
  - Required: completion still follows the latched value.
- Cancel:
  - With `COUNTER_SCHED_CANCEL_EN` defined, dropping the owner's `i_req` at count 2: grant clears next cycle and no `o_done` is issued.
  - Without the macro, the same stimulus still produces `o_done` at count == `dur_q`+1 cycle.

Source files
------------

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up-counter among NUM_REQ requesters.
// Optional `COUNTER_SCHED_CANCEL_EN: owner dropping its request during RUN abandons the interval.
module counter_sched #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             i_reset,
    input  logic [NUM_REQ-1:0]               i_req,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0]   i_duration,
    output logic [NUM_REQ-1:0]               o_grant,
    output logic [NUM_REQ-1:0]               o_done,
    output logic                             o_busy,
    output logic [COUNT_WIDTH-1:0]           o_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_done;
    logic                   r_busy;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_dur;
    logic [IDX_W-1:0]       r_last_grant;

    logic [COUNT_WIDTH-1:0] w_dur  [NUM_REQ];
    logic [IDX_W-1:0]       w_cand [NUM_REQ];
    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_cancel;

    // w_cand[gi] is the requester at round-robin distance gi+1 from the last owner.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rr
            logic [IDX_W:0] w_sum;
            assign w_dur[gi]  = i_duration[gi*COUNT_WIDTH +: COUNT_WIDTH];
            assign w_sum      = {1'b0, r_last_grant} + (IDX_W+1)'(gi + 1);
            assign w_cand[gi] = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                                IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(w_sum);
        end
    endgenerate

    // Scan farthest to nearest so the nearest pending requester wins.
    always_comb begin
        w_win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                w_win_idx = w_cand[k];
            end
        end
    end

`ifdef COUNTER_SCHED_CANCEL_EN
    assign w_cancel = ~|(i_req & r_grant);
`else
    assign w_cancel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_done       <= '0;
            r_busy       <= 1'b0;
            r_count      <= '0;
            r_dur        <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_state      <= S_RUN;
                        r_grant      <= NUM_REQ'(1) << w_win_idx;
                        r_busy       <= 1'b1;
                        r_count      <= '0;
                        r_dur        <= w_dur[w_win_idx];
                        r_last_grant <= w_win_idx;
                    end
                end
                S_RUN: begin
                    if (w_cancel) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else if (r_count == r_dur) begin
                        // Count is held; comparing before incrementing means no wrap at max duration.
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                    end else begin
                        r_count <= r_count + COUNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign o_grant = r_grant;
    assign o_done  = r_done;
    assign o_busy  = r_busy;
    assign o_count = r_count;

endmodule
